// File: rtl/subservient_dbg_fabric.sv
// Wishbone debug fabric: routes one host access at a time to a subservient core or a local CSR block.
// Optional broadcast-write target at index 2^SEL_W-2 when SUBSERVIENT_DBG_BCAST_EN is defined.
module subservient_dbg_fabric #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned SEL_LSB   = 20,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [31:0]            i_wb_adr,
    input  logic [31:0]            i_wb_dat,
    input  logic [3:0]             i_wb_sel,
    input  logic                   i_wb_we,
    input  logic                   i_wb_stb,
    output logic [31:0]            o_wb_rdt,
    output logic                   o_wb_ack,
    output logic [32*NUM_CORES-1:0] o_core_adr,
    output logic [32*NUM_CORES-1:0] o_core_dat,
    output logic [4*NUM_CORES-1:0] o_core_sel,
    output logic [NUM_CORES-1:0]   o_core_we,
    output logic [NUM_CORES-1:0]   o_core_stb,
    input  logic [32*NUM_CORES-1:0] i_core_rdt,
    input  logic [NUM_CORES-1:0]   i_core_ack,
    output logic [NUM_CORES-1:0]   o_core_dbg_mode,
    output logic [NUM_CORES-1:0]   o_core_rst
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TOI_W  = 8;
    localparam logic [SEL_W-1:0] IDX_CSR = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] IDX_LIM = SEL_W'(NUM_CORES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      ERR_DATA = 32'hDEAD_BEEF;
`ifdef SUBSERVIENT_DBG_BCAST_EN
    localparam logic [SEL_W-1:0] IDX_BCAST = {{(SEL_W-1){1'b1}}, 1'b0};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    ack_q, ack_d;
    logic [31:0]             rdt_q, rdt_d;
    logic [31:0]             resp_q, resp_d;
    logic [NUM_CORES-1:0]    stb_q, stb_d;
    logic [NUM_CORES-1:0]    we_q, we_d;
    logic [32*NUM_CORES-1:0] adr_q, adr_d;
    logic [32*NUM_CORES-1:0] dat_q, dat_d;
    logic [4*NUM_CORES-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CORES-1:0]    dbg_q, dbg_d;
    logic [NUM_CORES-1:0]    crst_q, crst_d;
    logic                    sto_q, sto_d;
    logic                    serr_q, serr_d;
    logic [TOI_W-1:0]        toidx_q, toidx_d;
`ifdef SUBSERVIENT_DBG_BCAST_EN
    logic                    bcast_q, bcast_d;
`endif

    logic [SEL_W-1:0]        idx;
    logic [NUM_CORES-1:0]    stb_left;
    logic [31:0]             ack_rdt;
    logic [31:0]             csr_rdata;
    logic [TOI_W-1:0]        low_idx;

    assign idx = i_wb_adr[SEL_LSB +: SEL_W];

    // State and all registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            rdt_q   <= '0;
            resp_q  <= '0;
            stb_q   <= '0;
            we_q    <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            dbg_q   <= '1;
            crst_q  <= '0;
            sto_q   <= 1'b0;
            serr_q  <= 1'b0;
            toidx_q <= '0;
`ifdef SUBSERVIENT_DBG_BCAST_EN
            bcast_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdt_q   <= rdt_d;
            resp_q  <= resp_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dbg_q   <= dbg_d;
            crst_q  <= crst_d;
            sto_q   <= sto_d;
            serr_q  <= serr_d;
            toidx_q <= toidx_d;
`ifdef SUBSERVIENT_DBG_BCAST_EN
            bcast_q <= bcast_d;
`endif
        end
    end

    // Decode, CSR access, core handshake and timeout
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        rdt_d     = '0;
        resp_d    = resp_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        dbg_d     = dbg_q;
        crst_d    = crst_q;
        sto_d     = sto_q;
        serr_d    = serr_q;
        toidx_d   = toidx_q;
`ifdef SUBSERVIENT_DBG_BCAST_EN
        bcast_d   = bcast_q;
`endif
        stb_left  = stb_q & ~i_core_ack;
        ack_rdt   = '0;
        low_idx   = '0;
        csr_rdata = '0;

        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (stb_q[k] && i_core_ack[k]) ack_rdt = i_core_rdt[32*k +: 32];
        end
        for (int k = int'(NUM_CORES) - 1; k >= 0; k--) begin
            if (stb_left[k]) low_idx = TOI_W'(k);
        end

        case (i_wb_adr[3:2])
            2'd0:    csr_rdata = 32'(dbg_q);
            2'd1:    csr_rdata = 32'(crst_q);
            2'd2:    csr_rdata = {16'h0, toidx_q, 6'h0, serr_q, sto_q};
            default: csr_rdata = '0;
        endcase

        case (state_q)
            IDLE: begin
                // The ack cycle still shows the finished request's strobe; skip it
                if (i_wb_stb && !ack_q) begin
                    if (idx < IDX_LIM) begin
                        for (int unsigned k = 0; k < NUM_CORES; k++) begin
                            if (idx == SEL_W'(k)) begin
                                stb_d[k]           = 1'b1;
                                we_d[k]            = i_wb_we;
                                adr_d[32*k +: 32]  = i_wb_adr;
                                dat_d[32*k +: 32]  = i_wb_dat;
                                sel_d[4*k +: 4]    = i_wb_sel;
                            end
                        end
                        cnt_d   = '0;
                        state_d = CORE;
                    end else if (idx == IDX_CSR) begin
                        resp_d  = csr_rdata;
                        state_d = RESP;
                        if (i_wb_we) begin
                            case (i_wb_adr[3:2])
                                2'd0: begin
                                    for (int unsigned i = 0; i < NUM_CORES; i++) begin
                                        if (i_wb_sel[i >> 3]) dbg_d[i] = i_wb_dat[i];
                                    end
                                end
                                2'd1: begin
                                    for (int unsigned i = 0; i < NUM_CORES; i++) begin
                                        if (i_wb_sel[i >> 3]) crst_d[i] = i_wb_dat[i];
                                    end
                                end
                                2'd2: begin
                                    if (i_wb_sel[0] && i_wb_dat[0]) sto_d  = 1'b0;
                                    if (i_wb_sel[0] && i_wb_dat[1]) serr_d = 1'b0;
                                end
                                default: ;
                            endcase
                        end
`ifdef SUBSERVIENT_DBG_BCAST_EN
                    end else if (idx == IDX_BCAST && i_wb_we) begin
                        stb_d   = '1;
                        we_d    = '1;
                        adr_d   = {NUM_CORES{i_wb_adr}};
                        dat_d   = {NUM_CORES{i_wb_dat}};
                        sel_d   = {NUM_CORES{i_wb_sel}};
                        bcast_d = 1'b1;
                        cnt_d   = '0;
                        state_d = CORE;
`endif
                    end else begin
                        resp_d  = ERR_DATA;
                        serr_d  = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            CORE: begin
                // Each strobe drops as its core acks; done once none remain
                stb_d = stb_left;
                if (stb_left == '0) begin
                    resp_d = ack_rdt;
`ifdef SUBSERVIENT_DBG_BCAST_EN
                    if (bcast_q) resp_d = '0;
                    bcast_d = 1'b0;
`endif
                    we_d    = '0;
                    adr_d   = '0;
                    dat_d   = '0;
                    sel_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    resp_d  = ERR_DATA;
                    sto_d   = 1'b1;
                    toidx_d = low_idx;
`ifdef SUBSERVIENT_DBG_BCAST_EN
                    bcast_d = 1'b0;
`endif
                    stb_d   = '0;
                    we_d    = '0;
                    adr_d   = '0;
                    dat_d   = '0;
                    sel_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                ack_d   = 1'b1;
                rdt_d   = resp_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_wb_ack        = ack_q;
    assign o_wb_rdt        = rdt_q;
    assign o_core_stb      = stb_q;
    assign o_core_we       = we_q;
    assign o_core_adr      = adr_q;
    assign o_core_dat      = dat_q;
    assign o_core_sel      = sel_q;
    assign o_core_dbg_mode = dbg_q;
    assign o_core_rst      = crst_q;

endmodule
